// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and widths for the data-memory port arbiter
package dmem_pkg;
   localparam int DMEM_ADDR_W = 8;
   localparam int DMEM_DATA_W = 64;
   typedef enum logic {OWN_CPU, OWN_LDR} owner_t;
   typedef enum logic {CPU_PRI, LDR_TURN} arb_state_t;
endpackage

// File: rtl/dmem_rd_return.sv
// dmem_rd_return: one-deep read tag and per-owner rvalid/rdata return path
module dmem_rd_return
   import dmem_pkg::*;
#(
   parameter int DATA_W = DMEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_issue,
   input  owner_t            rd_owner,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              ldr_rvalid,
   output logic [DATA_W-1:0] ldr_rdata
);
   logic              tag_valid_q, tag_valid_d;
   owner_t            tag_owner_q, tag_owner_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

   always_comb begin
      tag_valid_d = rd_issue;
      tag_owner_d = rd_issue ? rd_owner : tag_owner_q;
      cpu_rvalid  = tag_valid_q & (tag_owner_q == OWN_CPU);
      ldr_rvalid  = tag_valid_q & (tag_owner_q == OWN_LDR);
      // the port not being answered keeps showing its last returned word
      cpu_rdata   = cpu_rvalid ? mem_rdata : cpu_rdata_q;
      ldr_rdata   = ldr_rvalid ? mem_rdata : ldr_rdata_q;
      cpu_rdata_d = cpu_rdata;
      ldr_rdata_d = ldr_rdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_valid_q <= 1'b0;
         tag_owner_q <= OWN_CPU;
         cpu_rdata_q <= '0;
         ldr_rdata_q <= '0;
      end else begin
         tag_valid_q <= tag_valid_d;
         tag_owner_q <= tag_owner_d;
         cpu_rdata_q <= cpu_rdata_d;
         ldr_rdata_q <= ldr_rdata_d;
      end
   end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: cpu-priority sharing of the data memory with bounded loader starvation
module dmem_port_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = DMEM_ADDR_W,
   parameter int DATA_W   = DMEM_DATA_W,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_gnt,
   output logic              ldr_rvalid,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam logic [3:0] MAX_H = 4'(MAX_HOLD);

   arb_state_t state_q, state_d;
   logic [3:0] hold_cnt_q, hold_cnt_d;
   logic [3:0] hold_inc;
   logic       contend, any_gnt, we_sel;

   always_comb begin
      // grants are forced low while reset is held so nothing reaches memory
      cpu_gnt    = rst_n & cpu_req & ((state_q == CPU_PRI) | ~ldr_req);
      ldr_gnt    = rst_n & ldr_req & ~cpu_gnt;
      cpu_stall  = rst_n & cpu_req & ~cpu_gnt;
      any_gnt    = cpu_gnt | ldr_gnt;
      we_sel     = cpu_gnt ? cpu_we : ldr_we;
      mem_wr     = any_gnt & we_sel;
      mem_rd     = any_gnt & ~we_sel;
      mem_addr   = cpu_gnt ? cpu_addr : ldr_gnt ? ldr_addr : '0;
      mem_wdata  = cpu_gnt ? cpu_wdata : ldr_gnt ? ldr_wdata : '0;
      contend    = (state_q == CPU_PRI) & cpu_gnt & ldr_req;
      hold_inc   = (hold_cnt_q == MAX_H) ? MAX_H : hold_cnt_q + 4'd1;
      hold_cnt_d = (contend && hold_inc != MAX_H) ? hold_inc : 4'd0;
      state_d    = (contend && hold_inc == MAX_H) ? LDR_TURN : CPU_PRI;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CPU_PRI;
         hold_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   dmem_rd_return #(.DATA_W(DATA_W)) u_rd_return (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_issue  (mem_rd),
      .rd_owner  (cpu_gnt ? OWN_CPU : OWN_LDR),
      .mem_rdata (mem_rdata),
      .cpu_rvalid(cpu_rvalid),
      .cpu_rdata (cpu_rdata),
      .ldr_rvalid(ldr_rvalid),
      .ldr_rdata (ldr_rdata)
   );
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed stimulus with a read-response scoreboard and a memory model
module tb_dmem_port_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we, ldr_req, ldr_we;
   logic [7:0]  cpu_addr, ldr_addr;
   logic [63:0] cpu_wdata, ldr_wdata;
   logic        cpu_gnt, cpu_stall, cpu_rvalid, ldr_gnt, ldr_rvalid;
   logic [63:0] cpu_rdata, ldr_rdata;
   logic        mem_wr, mem_rd;
   logic [7:0]  mem_addr;
   logic [63:0] mem_wdata, mem_rdata;

   typedef struct packed {
      logic        own;
      logic [63:0] d;
   } rsp_t;

   logic [63:0] mm [256];
   logic [63:0] ref_mem [256];
   rsp_t        q [$];
   logic [63:0] last_c, last_l;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.ADDR_W(8), .DATA_W(64), .MAX_HOLD(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
      .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_wr) mm[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= mm[mem_addr];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input logic cr, input logic cw, input logic [7:0] ca, input logic [63:0] cd,
                       input logic lr, input logic lw, input logic [7:0] la, input logic [63:0] ld,
                       input logic ec, input logic el);
      rsp_t e;
      logic ecv, elv;
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      ldr_req = lr; ldr_we = lw; ldr_addr = la; ldr_wdata = ld;
      @(negedge clk);
      ecv = 1'b0; elv = 1'b0;
      if (q.size() > 0) begin
         e = q.pop_front();
         if (e.own) begin elv = 1'b1; last_l = e.d; end
         else begin ecv = 1'b1; last_c = e.d; end
      end
      chk("cpu_rvalid", 64'(cpu_rvalid), 64'(ecv));
      chk("ldr_rvalid", 64'(ldr_rvalid), 64'(elv));
      chk("cpu_rdata", cpu_rdata, last_c);
      chk("ldr_rdata", ldr_rdata, last_l);
      chk("cpu_gnt", 64'(cpu_gnt), 64'(ec));
      chk("ldr_gnt", 64'(ldr_gnt), 64'(el));
      chk("cpu_stall", 64'(cpu_stall), 64'(cr & ~ec));
      chk("mem_wr", 64'(mem_wr), 64'((ec & cw) | (el & lw)));
      chk("mem_rd", 64'(mem_rd), 64'((ec & ~cw) | (el & ~lw)));
      chk("mem_addr", 64'(mem_addr), ec ? 64'(ca) : el ? 64'(la) : 64'd0);
      chk("mem_wdata", mem_wdata, ec ? cd : el ? ld : 64'd0);
      if (ec) begin
         if (cw) ref_mem[ca] = cd;
         else q.push_back('{own: 1'b0, d: ref_mem[ca]});
      end
      if (el) begin
         if (lw) ref_mem[la] = ld;
         else q.push_back('{own: 1'b1, d: ref_mem[la]});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0, 0, 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mm[i] = {32'hDEADBEEF, 24'h0, 8'(i)};
         ref_mem[i] = mm[i];
      end
      last_c = '0; last_l = '0;
      rst_n = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle();

      step(1, 0, 8'h10, 64'h0, 0, 0, 8'h00, 64'h0, 1, 0);
      idle();
      chk("rdata_0x10", cpu_rdata, 64'hDEADBEEF_00000010);

      step(0, 0, 8'h00, 64'h0, 1, 1, 8'h20, 64'h1234, 0, 1);
      step(1, 0, 8'h20, 64'h0, 0, 0, 8'h00, 64'h0, 1, 0);
      idle();
      chk("rdata_0x20", cpu_rdata, 64'h1234);

      for (int i = 0; i < 10; i++)
         step(1, 0, 8'h05, 64'h0, 1, 0, 8'h06, 64'h0, (i % 5) != 4, (i % 5) == 4);
      idle();

      step(1, 0, 8'h01, 64'h0, 0, 0, 8'h00, 64'h0, 1, 0);
      step(0, 0, 8'h00, 64'h0, 1, 0, 8'h02, 64'h0, 0, 1);
      step(1, 0, 8'h03, 64'h0, 0, 0, 8'h00, 64'h0, 1, 0);
      idle();
      idle();

      step(1, 1, 8'h30, 64'hA5A5, 1, 0, 8'h31, 64'h0, 1, 0);
      step(1, 0, 8'h30, 64'h0, 1, 0, 8'h31, 64'h0, 1, 0);
      step(1, 0, 8'h32, 64'h0, 0, 0, 8'h00, 64'h0, 1, 0);
      for (int i = 0; i < 5; i++)
         step(1, 0, 8'h33, 64'h0, 1, 0, 8'h31, 64'h0, i != 4, i == 4);
      idle();

      step(1, 0, 8'h44, 64'h0, 0, 0, 8'h00, 64'h0, 1, 0);
      rst_n = 1'b0;
      cpu_req = 1; ldr_req = 1; cpu_addr = 8'h45; ldr_addr = 8'h46;
      @(negedge clk);
      chk("rst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
      chk("rst_ldr_rvalid", 64'(ldr_rvalid), 64'd0);
      chk("rst_gnts", {62'd0, cpu_gnt, ldr_gnt}, 64'd0);
      chk("rst_stall", 64'(cpu_stall), 64'd0);
      chk("rst_strobes", {62'd0, mem_wr, mem_rd}, 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_rdata", cpu_rdata | ldr_rdata, 64'd0);
      q.delete();
      last_c = '0; last_l = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(1, 0, 8'h45, 64'h0, 1, 0, 8'h46, 64'h0, 1, 0);
      idle();
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory (8-bit address, 64-bit data) between two requesters:
  - the pipeline MEM stage (cpu port);
  - the program/data loader (ldr port).
- The cpu port has priority. A bounded-hold counter guarantees the loader progress.
- Read data is tagged with its owner and returned one cycle after issue. The block drives a stall to the pipeline hazard logic.

Parameters:
- ADDR_W, 8, address width of both ports and the memory.
- DATA_W, 64, data width.
- MAX_HOLD, 4, max consecutive contended cpu grants before one forced loader grant (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  MEM-stage access request; held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  cpu address.
- cpu_wdata  in  DATA_W  cpu write data.
- cpu_gnt  out  1  request accepted this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt.
- cpu_rvalid  out  1  cpu read data valid.
- cpu_rdata  out  DATA_W  cpu read data.
- ldr_req  in  1  loader request; held until granted.
- ldr_we  in  1  1 = write, 0 = read.
- ldr_addr  in  ADDR_W  loader address.
- ldr_wdata  in  DATA_W  loader write data.
- ldr_gnt  out  1  loader request accepted this cycle.
- ldr_rvalid  out  1  loader read data valid.
- ldr_rdata  out  DATA_W  loader read data.
- mem_wr  out  1  memory write strobe.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_rd.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = CPU_PRI, hold_cnt = 0, rd_tag_valid = 0.
  - All gnt/rvalid/mem_wr/mem_rd = 0; rdata outputs = 0.
- FSM, two states:
  - CPU_PRI, default:
    - cpu_req wins whenever asserted.
    - Loader granted only when cpu_req = 0.
  - LDR_TURN: loader wins if ldr_req; otherwise cpu is granted. Always returns to CPU_PRI next cycle.
- hold_cnt, in CPU_PRI:
  - Increments (saturating at MAX_HOLD) on each cycle with cpu_gnt & ldr_req.
  - Clears on any ldr_gnt or any cycle with ldr_req = 0.
  - When a contended cpu grant brings hold_cnt to MAX_HOLD, next state = LDR_TURN and hold_cnt clears.
- Grant and memory drive (combinational from state and reqs):
  - At most one gnt per cycle.
  - Granted port drives mem_addr/mem_wdata.
  - mem_wr = gnt & we; mem_rd = gnt & ~we.
  - No grant: mem_wr = mem_rd = 0, mem_addr/mem_wdata = 0.
- Read return, latency 1:
  - On a read grant, register rd_tag_valid = 1 and rd_tag_owner.
  - Next cycle the owner's rvalid = 1 and its rdata = mem_rdata.
  - The other port's rdata holds its last value.
  - Back-to-back reads by either port are allowed every cycle; responses stay in issue order.
- Writes: complete at the grant edge; no response.
- Simultaneous events: a new grant and an rvalid from the previous read may occur in the same cycle. Both are legal and independent.
- Idle: no req → no strobes; hold_cnt clears; state stays CPU_PRI.
- Reset mid-operation: an outstanding read is dropped (no rvalid after reset release); FSM returns to CPU_PRI.
- Requester rules:
  - Address, data and we must stay stable while req is high and ungranted.
  - req may be dropped only after gnt.

Decomposition:
- Shared package dmem_pkg:
  - typedef owner_t {OWN_CPU, OWN_LDR};
  - arb_state_t {CPU_PRI, LDR_TURN};
  - constants DMEM_ADDR_W = 8, DMEM_DATA_W = 64.
- One natural sub-module: dmem_rd_return (tag register plus rvalid/rdata demux), isolating the latency path from grant logic.

Test Plan:
- cpu_req only, read addr 0x10 (memory holds 0xDEADBEEF_00000010) → cpu_gnt same cycle, mem_rd = 1, mem_addr = 0x10; next cycle cpu_rvalid = 1, cpu_rdata = 0xDEADBEEF_00000010, ldr_rvalid = 0.
- ldr_req only, write 0x20 ← 0x1234 → ldr_gnt, mem_wr = 1, mem_wdata = 0x1234; a later cpu read of 0x20 returns 0x1234.
- cpu_req and ldr_req held continuously, MAX_HOLD = 4 → grant pattern cpu,cpu,cpu,cpu,ldr repeating; cpu_stall = 1 exactly on ldr cycles.
- Alternating reads cpu@0x01, ldr@0x02, cpu@0x03 on consecutive cycles → rvalids on the following cycles routed cpu, ldr, cpu with matching data; never both rvalid high.
- Contention for 2 cycles, then ldr_req low for one cycle → hold_cnt clears; the next 4 contended cycles go to cpu before a ldr turn.
- Assert rst_n = 0 the cycle after a cpu read grant → cpu_rvalid stays 0; all outputs 0 during reset; first post-reset grant goes to cpu when both request.
